hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter REG_AW, default 3: register-index width (8 architectural registers; r0 hardwired zero).
REQ-002 Parameter CNT_W, default 16: width of the stall and flush performance counters.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs1, id_rs2  in  REG_AW each  source registers of the ID instruction.
REQ-007 id_rd  in  REG_AW  destination register of the ID instruction.
REQ-008 id_reg_write, id_mem_read  in  1 each  ID instruction writes the register file / is a load.
REQ-009 branch_taken  in  1  branch or jump resolved taken in EX this cycle.
REQ-010 fwd_a, fwd_b  out  2 each  operand selects for the 16-bit forwarding muxes: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 never driven.
REQ-011 stall  out  1  load-use bubble this cycle.
REQ-012 pc_write, ifid_write  out  1 each  PC / IF-ID register enables.
REQ-013 flush_if, flush_id  out  1 each  squash the IF and ID instructions.
REQ-014 stall_count, flush_count  out  CNT_W each  saturating event counters.

Function
REQ-015 Internal tracking registers SHALL hold the EX slot (rs1, rs2, rd, reg_write, mem_read), the MEM slot (rd, reg_write) and the WB slot (rd, reg_write).
REQ-016 Each cycle: WB <= MEM, MEM <= EX, and EX <= ID fields when id_valid=1, stall=0 and branch_taken=0; otherwise EX <= bubble (reg_write=0, mem_read=0, all indices 0).
REQ-017 fwd_a SHALL be 01 when MEM.reg_write=1, MEM.rd!=0 and MEM.rd==EX.rs1; else 10 when WB.reg_write=1, WB.rd!=0 and WB.rd==EX.rs1; else 00.
REQ-018 fwd_b SHALL follow REQ-017 with EX.rs2; when MEM and WB both match, 01 (most recent result) wins.
REQ-019 fwd_a/fwd_b SHALL be combinational from tracking registers only, valid in the same cycle the instruction occupies EX.
REQ-020 Load-use: stall=1 when EX.mem_read=1, EX.rd!=0, id_valid=1, branch_taken=0, and EX.rd equals id_rs1 or id_rs2.
REQ-021 While stall=1: pc_write=0, ifid_write=0, bubble into EX; stall lasts exactly one cycle since the load advances to MEM and the dependency is then served by fwd=10.
REQ-022 branch_taken=1: flush_if=1, flush_id=1, pc_write=1, ifid_write=1, stall=0, bubble into EX next cycle; flush SHALL take priority over a simultaneous load-use.
REQ-023 Otherwise pc_write=1, ifid_write=1, flush_if=0, flush_id=0.
REQ-024 stall_count SHALL increment by 1 on each cycle with stall=1; flush_count on each cycle with branch_taken=1; both saturate at all-ones and never wrap.
REQ-025 Back-to-back branch_taken cycles SHALL each flush and each count; a load in EX squashed by nothing continues normally.

Reset
REQ-026 rst_n=0 SHALL immediately clear all tracking slots to bubbles and both counters to 0, independent of clk.
REQ-027 During and after reset until new state: fwd_a=fwd_b=00, stall=0, pc_write=1, ifid_write=1, flush_if=flush_id=0.
REQ-028 Reset asserted mid-stall SHALL drop stall to 0 asynchronously; first cycle after deassertion behaves as from empty pipeline.

Verification
REQ-029 ADD r3 in EX, SUB reads r3 next cycle -> in SUB's EX cycle fwd_a=01; one cycle later WB-only match on another reader -> 10.
REQ-030 r3 written in MEM and WB simultaneously, EX reads r3 on rs2 -> fwd_b=01; writes to r0 in MEM/WB -> fwd_a=fwd_b=00.
REQ-031 LOAD r2 in EX, ID reads r2 on rs1 -> stall=1, pc_write=0, ifid_write=0 for one cycle, stall_count 0->1, then fwd_a=10.
REQ-032 Load-use and branch_taken same cycle -> stall=0, flush_if=flush_id=1, pc_write=1, flush_count +1, stall_count unchanged.
REQ-033 Force stall_count to 2^CNT_W-1 via repeated load-use (CNT_W=4: 16 stalls) -> holds at 15.
REQ-034 rst_n low for 1 ns mid-stall between clock edges -> stall, counters, fwd selects return to reset values immediately.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use stall, branch flush,
// and saturating stall/flush event counters for a 5-stage in-order core.
module hazard_unit #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              flush_if,
  output logic              flush_id,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
  logic              ex_load_id;
  fwd_sel_e          sel_a, sel_b;

  // A slot only forwards if it writes a register other than r0.
  logic mem_fwd_ok, wb_fwd_ok;
  assign mem_fwd_ok = mem_reg_write && (mem_rd != '0);
  assign wb_fwd_ok  = wb_reg_write  && (wb_rd  != '0);

  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (mem_fwd_ok && (mem_rd == ex_rs1))     sel_a = FWD_MEM;
    else if (wb_fwd_ok && (wb_rd == ex_rs1))  sel_a = FWD_WB;
    if (mem_fwd_ok && (mem_rd == ex_rs2))     sel_b = FWD_MEM;
    else if (wb_fwd_ok && (wb_rd == ex_rs2))  sel_b = FWD_WB;
  end

  assign fwd_a = sel_a;
  assign fwd_b = sel_b;

  // Flush wins over load-use: a taken branch squashes the dependent ID instruction anyway.
  always_comb begin
    stall = 1'b0;
    if (ex_mem_read && (ex_rd != '0) && id_valid && !branch_taken &&
        ((ex_rd == id_rs1) || (ex_rd == id_rs2)))
      stall = 1'b1;
  end

  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign flush_if   = branch_taken;
  assign flush_id   = branch_taken;
  assign ex_load_id = id_valid && !stall && !branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
    end else begin
      wb_rd         <= mem_rd;
      wb_reg_write  <= mem_reg_write;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      if (ex_load_id) begin
        ex_rs1       <= id_rs1;
        ex_rs2       <= id_rs2;
        ex_rd        <= id_rd;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
      end else begin
        ex_rs1       <= '0;
        ex_rs2       <= '0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (branch_taken && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed hazard scenarios plus random traffic,
// all outputs compared each cycle against a slot-list pipeline model.
module tb_hazard_unit;

  localparam int unsigned AW = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0, branch_taken = 1'b0;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, pc_write, ifid_write, flush_if, flush_id;
  logic [CW-1:0] stall_count, flush_count;

  hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .pc_write(pc_write),
    .ifid_write(ifid_write), .flush_if(flush_if), .flush_id(flush_id),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: slot[0]=EX, slot[1]=MEM, slot[2]=WB; index k is also the distance
  // back to the producer, which is exactly the forwarding encoding.
  typedef struct {
    int rs1, rs2, rd;
    bit rw, mr;
  } slot_t;

  slot_t slot[3];
  int    m_sc, m_fc;

  function automatic slot_t bubble();
    slot_t s;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.rw = 0; s.mr = 0;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) slot[k] = bubble();
    m_sc = 0;
    m_fc = 0;
  endtask

  function automatic int exp_fwd(int src);
    for (int k = 1; k <= 2; k++)
      if (slot[k].rw && slot[k].rd != 0 && slot[k].rd == src) return k;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (!rst_n || branch_taken || !id_valid) return 0;
    return slot[0].mr && slot[0].rd != 0 &&
           (slot[0].rd == int'(id_rs1) || slot[0].rd == int'(id_rs2));
  endfunction

  task automatic check_all();
    bit s;
    s = exp_stall();
    check("fwd_a", 32'(fwd_a), 32'(exp_fwd(slot[0].rs1)));
    check("fwd_b", 32'(fwd_b), 32'(exp_fwd(slot[0].rs2)));
    check("stall", 32'(stall), 32'(s));
    check("pc_write", 32'(pc_write), 32'(!s));
    check("ifid_write", 32'(ifid_write), 32'(!s));
    check("flush_if", 32'(flush_if), 32'(branch_taken && rst_n));
    check("flush_id", 32'(flush_id), 32'(branch_taken && rst_n));
    check("stall_count", 32'(stall_count), 32'(m_sc));
    check("flush_count", 32'(flush_count), 32'(m_fc));
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input bit mr, input bit br);
    @(negedge clk);
    id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_rd = AW'(rd);
    id_reg_write = rw; id_mem_read = mr; branch_taken = br;
    #1 check_all();
  endtask

  task automatic tick();
    bit s;
    slot_t nx;
    @(posedge clk);
    s = exp_stall();
    if (s && m_sc < int'(CMAX)) m_sc++;
    if (branch_taken && m_fc < int'(CMAX)) m_fc++;
    nx = bubble();
    if (id_valid && !s && !branch_taken) begin
      nx.rs1 = int'(id_rs1); nx.rs2 = int'(id_rs2); nx.rd = int'(id_rd);
      nx.rw = id_reg_write; nx.mr = id_mem_read;
    end
    slot[2] = slot[1];
    slot[1] = slot[0];
    slot[0] = nx;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    id_valid = 0; branch_taken = 0; id_mem_read = 0; id_reg_write = 0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 check_all();
    do_reset();

    // ADD r3; SUB reads r3 -> MEM forward; a later reader sees WB forward.
    drive(1, 1, 2, 3, 1, 0, 0); tick();
    drive(1, 3, 1, 4, 1, 0, 0); tick();
    drive(1, 3, 5, 5, 1, 0, 0); check("sub_fwd_a_mem", 32'(fwd_a), 32'd1); tick();
    drive(0, 0, 0, 0, 0, 0, 0); check("rdr_fwd_a_wb", 32'(fwd_a), 32'd2); tick();

    // r3 in both MEM and WB -> youngest wins; r0 writers never forward.
    drive(1, 0, 0, 3, 1, 0, 0); tick();
    drive(1, 0, 0, 3, 1, 0, 0); tick();
    drive(1, 1, 3, 6, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); check("both_fwd_b", 32'(fwd_b), 32'd1); tick();
    drive(1, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 6, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("r0_fwd_a", 32'(fwd_a), 32'd0);
    check("r0_fwd_b", 32'(fwd_b), 32'd0);
    tick();

    // Load-use: one bubble, then WB forward.
    do_reset();
    drive(1, 0, 0, 2, 1, 1, 0); tick();
    drive(1, 2, 0, 4, 1, 0, 0);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_pc_write", 32'(pc_write), 32'd0);
    check("lu_ifid_write", 32'(ifid_write), 32'd0);
    tick();
    drive(1, 2, 0, 4, 1, 0, 0);
    check("lu_stall_once", 32'(stall), 32'd0);
    check("lu_scount", 32'(stall_count), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); check("lu_fwd_a_wb", 32'(fwd_a), 32'd2); tick();

    // Load-use coinciding with a taken branch: flush wins.
    drive(1, 0, 0, 2, 1, 1, 0); tick();
    drive(1, 2, 2, 4, 1, 0, 1);
    check("br_stall", 32'(stall), 32'd0);
    check("br_flush_if", 32'(flush_if), 32'd1);
    check("br_pc_write", 32'(pc_write), 32'd1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("br_fcount", 32'(flush_count), 32'd2);
    check("br_scount", 32'(stall_count), 32'd1);
    tick();

    // Saturate stall counter with 17 load-use events.
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 5, 1, 1, 0); tick();
      drive(1, 0, 5, 6, 1, 0, 0); tick();
      drive(1, 0, 5, 6, 1, 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("sat_scount", 32'(stall_count), 32'(CMAX));
    tick();

    // Async reset pulse while stalled, between clock edges.
    drive(1, 0, 0, 7, 1, 1, 0); tick();
    drive(1, 7, 0, 1, 1, 0, 0);
    check("mid_stall_pre", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_scount", 32'(stall_count), 32'd0);
    rst_n = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();

    // Random traffic, small register space to make hazards frequent.
    for (int i = 0; i < 600; i++) begin
      drive(bit'($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
            bit'($urandom_range(0, 7) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
